r_format_multicycle_cpu: RTL and testbench
==========================================

Name: r_format_multicycle_cpu

Overview:
Parametrised multi-cycle successor to the single-cycle R-format CPU. It executes MIPS R-format instructions over a fetch/decode/execute/writeback FSM, and it fetches from an external instruction port with a valid handshake. It adds start/halt control, a debug port for register preload and dump (replaces hierarchical bench access), and illegal-instruction detection. It sits between the instruction memory model and the bench or top-level controller.

Parameters:
DATA_W, 32, register and ALU datapath width (>=8)
REG_NUM, 32, number of architectural registers (power of 2)
ADDR_W, 32, PC and instruction address width
IMEM_BYTES, 128, instruction space size in bytes; program ends when PC >= IMEM_BYTES-4

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins execution at PC 0 from IDLE or HALT
instr_req  out  1  fetch request, held high until instr_valid
instr_addr  out  ADDR_W  byte address of the fetch (= PC, word aligned)
instr_valid  in  1  instr_data valid this cycle
instr_data  in  32  fetched instruction word
dbg_we  in  1  debug register write; honoured only in IDLE/HALT
dbg_addr  in  log2(REG_NUM)  debug read/write register index
dbg_wdata  in  DATA_W  debug write data
dbg_rdata  out  DATA_W  combinational read of R[dbg_addr]
pc  out  ADDR_W  current PC
busy  out  1  high in FETCH..WB
done  out  1  one-cycle pulse on entry to HALT
illegal  out  1  sticky; set by non-zero opcode or unsupported funct

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=0, all R[i]=0, instr_req=0, busy=0, done=0, illegal=0. Reset mid-instruction aborts the instruction with no register write.
- States: IDLE -> (start) FETCH -> (instr_valid) DECODE -> EXEC -> WB -> FETCH, or HALT if the next PC >= IMEM_BYTES-4. HALT -> (start) FETCH with pc=0 and illegal cleared.
- FETCH: instr_req=1 and instr_addr=pc. instr_data is latched into IR on the cycle instr_valid=1. With no wait states, one instruction takes 4 cycles; every instr_valid wait cycle adds one.
- DECODE: rs=IR[25:21], rt=IR[20:16], rd=IR[15:11], shamt=IR[10:6], funct=IR[5:0]. A, B <= R[rs], R[rt]. Indices are truncated to log2(REG_NUM) bits.
- EXEC functs:
  - 0x20 add, 0x22 sub (both wrap modulo 2^DATA_W, no overflow trap)
  - 0x24 and, 0x25 or, 0x27 nor
  - 0x2A slt (signed), 0x2B sltu
  - 0x00 sll, 0x02 srl (B shifted by shamt; shamt >= DATA_W gives 0)
- WB: R[rd] <= ALUOut, and pc <= pc+4.
  - Writes to R[0] are discarded; R[0] always reads 0.
  - If opcode != 0 or funct is unsupported: no write, illegal=1, pc still advances (executes as a NOP).
- start while busy is ignored. dbg_we while busy is ignored.
- PC wraps modulo 2^ADDR_W; this is unreachable when IMEM_BYTES < 2^ADDR_W.

Optional Feature:
PERF_CNT_EN defined adds the following outputs, cleared on reset and on start:
- cycle_cnt (32 bits): counts cycles with busy=1.
- instr_cnt (32 bits): counts WB entries.
- stall_cnt (32 bits): counts FETCH cycles with instr_valid=0.
- All three counters saturate at all-ones.

Without PERF_CNT_EN, these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
Package r_format_pkg holds:
- funct localparams
- state enum (IDLE, FETCH, DECODE, EXEC, WB, HALT)
- opcode/field bit positions
- ALU op encoding

One sub-module, rf_2r1w: REG_NUM x DATA_W register file with two async read ports, one sync write port, an R0-hardwired-zero rule and async-active-low clear. The debug read uses a third read port in the same sub-module.

Test Plan:
- Preload R1=5, R2=3 via dbg. Program: add $3,$1,$2; sub $4,$1,$2; slt $5,$2,$1. Zero-wait memory -> R3=8, R4=2, R5=1; each instruction takes 4 cycles.
- add $0,$1,$2 with R1=7 -> R0 stays 0 and dbg_rdata(0)=0.
- instr_valid withheld for 3 cycles on one fetch -> instr_req stays high, pc is stable, that instruction takes 7 cycles, and no result changes.
- Opcode 0x23 (lw) at address 8 -> illegal=1 and no register written; the next instruction at 12 still executes. illegal clears on the next start from HALT.
- Full 128-byte program -> done pulses once with pc=124 (0x7C). A start pulse issued while busy is ignored.
- rst_n low during EXEC of add $6,... -> R6 and all registers are 0, state is IDLE, busy=0, instr_req=0 immediately (asynchronously).

Source files
------------

// File: rtl/r_format_pkg.sv
// Shared definitions for the multi-cycle R-format CPU: instruction field layout,
// funct codes, FSM state encoding and the internal ALU operation encoding.
package r_format_pkg;

    localparam int OPC_LSB   = 26;
    localparam int OPC_W     = 6;
    localparam int RS_LSB    = 21;
    localparam int RT_LSB    = 16;
    localparam int RD_LSB    = 11;
    localparam int SHAMT_LSB = 6;
    localparam int SHAMT_W   = 5;
    localparam int FUNCT_LSB = 0;
    localparam int FUNCT_W   = 6;

    localparam logic [5:0] FUNCT_SLL  = 6'h00;
    localparam logic [5:0] FUNCT_SRL  = 6'h02;
    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_NOR  = 6'h27;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;
    localparam logic [5:0] FUNCT_SLTU = 6'h2B;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_ILL
    } alu_op_e;

    // ALU_ILL marks any funct this core does not implement.
    function automatic alu_op_e decode_funct(input logic [5:0] funct);
        case (funct)
            FUNCT_ADD:  return ALU_ADD;
            FUNCT_SUB:  return ALU_SUB;
            FUNCT_AND:  return ALU_AND;
            FUNCT_OR:   return ALU_OR;
            FUNCT_NOR:  return ALU_NOR;
            FUNCT_SLT:  return ALU_SLT;
            FUNCT_SLTU: return ALU_SLTU;
            FUNCT_SLL:  return ALU_SLL;
            FUNCT_SRL:  return ALU_SRL;
            default:    return ALU_ILL;
        endcase
    endfunction

endpackage

// File: rtl/r_format_multicycle_cpu_rf.sv
// rf_2r1w: REG_NUM x DATA_W register file, two async operand reads, one async
// debug read, one sync write, R0 hardwired to zero, async active-low clear.
module rf_2r1w #(
    parameter int DATA_W  = 32,
    parameter int REG_NUM = 32,
    parameter int IDX_W   = $clog2(REG_NUM)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  i_ra1,
    input  logic [IDX_W-1:0]  i_ra2,
    input  logic [IDX_W-1:0]  i_ra3,
    output logic [DATA_W-1:0] o_rd1,
    output logic [DATA_W-1:0] o_rd2,
    output logic [DATA_W-1:0] o_rd3,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_wa,
    input  logic [DATA_W-1:0] i_wd
);

    logic [DATA_W-1:0] r_mem [REG_NUM];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_NUM; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (i_wa != '0)) begin
            r_mem[i_wa] <= i_wd;
        end
    end

    // Index 0 is decoded to zero on read so R0 never depends on storage.
    assign o_rd1 = (i_ra1 == '0) ? '0 : r_mem[i_ra1];
    assign o_rd2 = (i_ra2 == '0) ? '0 : r_mem[i_ra2];
    assign o_rd3 = (i_ra3 == '0) ? '0 : r_mem[i_ra3];

endmodule

// File: rtl/r_format_multicycle_cpu.sv
// Multi-cycle MIPS R-format CPU: FETCH/DECODE/EXEC/WB over a valid-handshake fetch
// port, with start/halt, debug register access and sticky illegal detection.
// Optional PERF_CNT_EN adds saturating cycle/instruction/stall counters.
module r_format_multicycle_cpu
    import r_format_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_NUM    = 32,
    parameter int ADDR_W     = 32,
    parameter int IMEM_BYTES = 128
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    output logic                       instr_req,
    output logic [ADDR_W-1:0]          instr_addr,
    input  logic                       instr_valid,
    input  logic [31:0]                instr_data,
    input  logic                       dbg_we,
    input  logic [$clog2(REG_NUM)-1:0] dbg_addr,
    input  logic [DATA_W-1:0]          dbg_wdata,
    output logic [DATA_W-1:0]          dbg_rdata,
    output logic [ADDR_W-1:0]          pc,
    output logic                       busy,
    output logic                       done,
    output logic                       illegal,
    output logic [2:0]                 dbg_state
`ifdef PERF_CNT_EN
    ,
    output logic [31:0]                cycle_cnt,
    output logic [31:0]                instr_cnt,
    output logic [31:0]                stall_cnt
`endif
);

    localparam int IDX_W = $clog2(REG_NUM);
    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(IMEM_BYTES - 4);
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    state_e              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [31:0]         r_ir;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [DATA_W-1:0]   r_alu_out;
    logic                r_wr_ok;
    logic                r_busy;
    logic                r_instr_req;
    logic                r_done;
    logic                r_illegal;

    logic [OPC_W-1:0]    w_opcode;
    logic [FUNCT_W-1:0]  w_funct;
    logic [SHAMT_W-1:0]  w_shamt;
    logic [IDX_W-1:0]    w_rs;
    logic [IDX_W-1:0]    w_rt;
    logic [IDX_W-1:0]    w_rd;
    alu_op_e             w_alu_op;
    logic                w_legal;
    logic                w_shamt_oob;
    logic [DATA_W-1:0]   w_alu_res;
    logic [DATA_W-1:0]   w_rd1;
    logic [DATA_W-1:0]   w_rd2;
    logic                w_idle;
    logic                w_rf_we;
    logic [IDX_W-1:0]    w_wa;
    logic [DATA_W-1:0]   w_wd;
    logic [ADDR_W-1:0]   w_pc_next;

    assign w_opcode    = r_ir[OPC_LSB +: OPC_W];
    assign w_funct     = r_ir[FUNCT_LSB +: FUNCT_W];
    assign w_shamt     = r_ir[SHAMT_LSB +: SHAMT_W];
    assign w_rs        = r_ir[RS_LSB +: IDX_W];
    assign w_rt        = r_ir[RT_LSB +: IDX_W];
    assign w_rd        = r_ir[RD_LSB +: IDX_W];
    assign w_alu_op    = decode_funct(w_funct);
    assign w_legal     = (w_opcode == '0) && (w_alu_op != ALU_ILL);
    assign w_shamt_oob = (32'(w_shamt) >= 32'(DATA_W));
    assign w_pc_next   = r_pc + PC_STEP;
    assign w_idle      = (r_state == IDLE) || (r_state == HALT);

    always_comb begin
        w_alu_res = '0;
        case (w_alu_op)
            ALU_ADD:  w_alu_res = r_a + r_b;
            ALU_SUB:  w_alu_res = r_a - r_b;
            ALU_AND:  w_alu_res = r_a & r_b;
            ALU_OR:   w_alu_res = r_a | r_b;
            ALU_NOR:  w_alu_res = ~(r_a | r_b);
            ALU_SLT:  w_alu_res = {{(DATA_W-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
            ALU_SLTU: w_alu_res = {{(DATA_W-1){1'b0}}, (r_a < r_b)};
            ALU_SLL:  w_alu_res = w_shamt_oob ? '0 : (r_b << w_shamt);
            ALU_SRL:  w_alu_res = w_shamt_oob ? '0 : (r_b >> w_shamt);
            default:  w_alu_res = '0;
        endcase
    end

    // The write port is shared: WB owns it while running, the debug port otherwise.
    assign w_rf_we = ((r_state == WB) && r_wr_ok) || (w_idle && dbg_we);
    assign w_wa    = (r_state == WB) ? w_rd : dbg_addr;
    assign w_wd    = (r_state == WB) ? r_alu_out : dbg_wdata;

    rf_2r1w #(
        .DATA_W  (DATA_W),
        .REG_NUM (REG_NUM),
        .IDX_W   (IDX_W)
    ) u_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .i_ra1 (w_rs),
        .i_ra2 (w_rt),
        .i_ra3 (dbg_addr),
        .o_rd1 (w_rd1),
        .o_rd2 (w_rd2),
        .o_rd3 (dbg_rdata),
        .i_we  (w_rf_we),
        .i_wa  (w_wa),
        .i_wd  (w_wd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_pc        <= '0;
            r_ir        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_alu_out   <= '0;
            r_wr_ok     <= 1'b0;
            r_busy      <= 1'b0;
            r_instr_req <= 1'b0;
            r_done      <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, HALT: begin
                    if (start) begin
                        r_state     <= FETCH;
                        r_pc        <= '0;
                        r_illegal   <= 1'b0;
                        r_busy      <= 1'b1;
                        r_instr_req <= 1'b1;
                    end
                end
                FETCH: begin
                    if (instr_valid) begin
                        r_ir        <= instr_data;
                        r_instr_req <= 1'b0;
                        r_state     <= DECODE;
                    end
                end
                DECODE: begin
                    r_a     <= w_rd1;
                    r_b     <= w_rd2;
                    r_state <= EXEC;
                end
                EXEC: begin
                    r_alu_out <= w_alu_res;
                    r_wr_ok   <= w_legal;
                    r_state   <= WB;
                end
                WB: begin
                    // An illegal instruction still retires as a NOP so the PC advances.
                    r_pc <= w_pc_next;
                    if (!r_wr_ok) begin
                        r_illegal <= 1'b1;
                    end
                    if (w_pc_next >= LAST_PC) begin
                        r_state <= HALT;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state     <= FETCH;
                        r_instr_req <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_busy      <= 1'b0;
                    r_instr_req <= 1'b0;
                end
            endcase
        end
    end

    assign instr_req  = r_instr_req;
    assign instr_addr = r_pc;
    assign pc         = r_pc;
    assign busy       = r_busy;
    assign done       = r_done;
    assign illegal    = r_illegal;
    assign dbg_state  = r_state;

`ifdef PERF_CNT_EN
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_instr_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
            r_stall_cnt <= '0;
        end else if (w_idle && start) begin
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (r_busy && (r_cycle_cnt != '1)) begin
                r_cycle_cnt <= r_cycle_cnt + 32'd1;
            end
            if ((r_state == WB) && (r_instr_cnt != '1)) begin
                r_instr_cnt <= r_instr_cnt + 32'd1;
            end
            if ((r_state == FETCH) && !instr_valid && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign cycle_cnt = r_cycle_cnt;
    assign instr_cnt = r_instr_cnt;
    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_r_format_multicycle_cpu.sv
// Directed bench for r_format_multicycle_cpu: program runs against a small
// instruction memory model, register results checked through the debug port.
module tb_r_format_multicycle_cpu;

    localparam int DATA_W     = 32;
    localparam int REG_NUM    = 32;
    localparam int ADDR_W     = 32;
    localparam int IMEM_BYTES = 128;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_EXEC = 3'd3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic              instr_req;
    logic [ADDR_W-1:0] instr_addr;
    logic              instr_valid;
    logic [31:0]       instr_data;
    logic              dbg_we = 1'b0;
    logic [4:0]        dbg_addr = '0;
    logic [DATA_W-1:0] dbg_wdata = '0;
    logic [DATA_W-1:0] dbg_rdata;
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic              done;
    logic              illegal;
    logic [2:0]        dbg_state;
`ifdef PERF_CNT_EN
    logic [31:0]       cycle_cnt;
    logic [31:0]       instr_cnt;
    logic [31:0]       stall_cnt;
`endif

    r_format_multicycle_cpu #(
        .DATA_W     (DATA_W),
        .REG_NUM    (REG_NUM),
        .ADDR_W     (ADDR_W),
        .IMEM_BYTES (IMEM_BYTES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .instr_req   (instr_req),
        .instr_addr  (instr_addr),
        .instr_valid (instr_valid),
        .instr_data  (instr_data),
        .dbg_we      (dbg_we),
        .dbg_addr    (dbg_addr),
        .dbg_wdata   (dbg_wdata),
        .dbg_rdata   (dbg_rdata),
        .pc          (pc),
        .busy        (busy),
        .done        (done),
        .illegal     (illegal),
        .dbg_state   (dbg_state)
`ifdef PERF_CNT_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .instr_cnt   (instr_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- instruction memory model ----------------
    logic [31:0] imem [32];
    int          stall_at [32];
    int          waited = 0;

    assign instr_valid = instr_req && (waited >= stall_at[instr_addr[6:2]]);
    assign instr_data  = imem[instr_addr[6:2]];

    always @(posedge clk) begin
        if (instr_req && !instr_valid) waited <= waited + 1;
        else                           waited <= 0;
    end

    // ---------------- scoreboard ----------------
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];
    logic [4:0]  exp_idx_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic expect_reg(input logic [4:0] idx, input logic [31:0] val);
        exp_idx_q.push_back(idx);
        exp_q.push_back(val);
    endtask

    task automatic drain_regs(input string tag);
        logic [4:0]  idx;
        logic [31:0] val;
        while (exp_q.size() > 0) begin
            idx = exp_idx_q.pop_front();
            val = exp_q.pop_front();
            dbg_addr = idx;
            #1;
            chk($sformatf("%s_R%0d", tag, idx), dbg_rdata, val);
        end
    endtask

    // ---------------- driver tasks ----------------
    function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd,
                                          input int sh, input int fn);
        return {6'b0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < 32; i++) begin
            imem[i]     = 32'h0;
            stall_at[i] = 0;
        end
    endtask

    task automatic dbg_write(input logic [4:0] idx, input logic [31:0] val);
        @(negedge clk);
        dbg_addr  = idx;
        dbg_wdata = val;
        dbg_we    = 1'b1;
        @(negedge clk);
        dbg_we    = 1'b0;
    endtask

    int          hs_cyc [32];
    int          hs_n;
    int          run_cycles;
    int          run_dones;
    int          stall_seen;
    logic [31:0] stall_pc;
    logic        ill_at_start;

    // Pulses start, then samples once per cycle until done or the budget runs out.
    task automatic run_prog(input int glitch_at);
        bit seen_done;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ill_at_start = illegal;
        hs_n = 0; run_cycles = 0; run_dones = 0; stall_seen = 0; stall_pc = '0;
        seen_done = 1'b0;
        for (int t = 0; t < 2000 && !seen_done; t++) begin
            if (busy) run_cycles++;
            if (instr_req && instr_valid && hs_n < 32) begin
                hs_cyc[hs_n] = t;
                hs_n++;
            end
            if (instr_req && !instr_valid) begin
                stall_seen++;
                stall_pc = pc;
            end
            if (done) begin
                run_dones++;
                seen_done = 1'b1;
            end
            if (t == glitch_at) begin
                start = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd20; dbg_wdata = 32'hDEAD;
            end else begin
                start = 1'b0; dbg_we = 1'b0;
            end
            @(negedge clk);
        end
        chk("run_reached_done", {31'b0, seen_done}, 32'd1);
        for (int t = 0; t < 4; t++) begin
            if (done) run_dones++;
            @(negedge clk);
        end
    endtask

    task automatic load_prog_a();
        clear_prog();
        imem[0]  = r_ins(1, 2, 3, 0, 'h20);
        imem[1]  = r_ins(1, 2, 4, 0, 'h22);
        imem[2]  = r_ins(2, 1, 5, 0, 'h2A);
        imem[3]  = r_ins(1, 2, 6, 0, 'h24);
        imem[4]  = r_ins(1, 2, 7, 0, 'h25);
        imem[5]  = r_ins(1, 2, 8, 0, 'h27);
        imem[6]  = r_ins(11, 1, 9, 0, 'h2A);
        imem[7]  = r_ins(11, 1, 10, 0, 'h2B);
        imem[8]  = r_ins(1, 11, 12, 0, 'h2A);
        imem[9]  = r_ins(1, 11, 13, 0, 'h2B);
        imem[10] = r_ins(0, 2, 14, 4, 'h00);
        imem[11] = r_ins(0, 11, 15, 28, 'h02);
        imem[12] = r_ins(2, 1, 16, 0, 'h22);
        imem[13] = r_ins(11, 1, 17, 0, 'h20);
        imem[14] = r_ins(1, 2, 0, 0, 'h20);
        imem[15] = r_ins(0, 11, 18, 0, 'h02);
    endtask

    task automatic expect_prog_a();
        expect_reg(0, 32'h0);
        expect_reg(1, 32'd5);
        expect_reg(2, 32'd3);
        expect_reg(3, 32'd8);
        expect_reg(4, 32'd2);
        expect_reg(5, 32'd1);
        expect_reg(6, 32'd1);
        expect_reg(7, 32'd7);
        expect_reg(8, 32'hFFFF_FFF8);
        expect_reg(9, 32'd1);
        expect_reg(10, 32'd0);
        expect_reg(11, 32'hFFFF_FFFF);
        expect_reg(12, 32'd0);
        expect_reg(13, 32'd1);
        expect_reg(14, 32'h30);
        expect_reg(15, 32'hF);
        expect_reg(16, 32'hFFFF_FFFE);
        expect_reg(17, 32'd4);
        expect_reg(18, 32'hFFFF_FFFF);
    endtask

    task automatic preload_a();
        dbg_write(1, 32'd5);
        dbg_write(2, 32'd3);
        dbg_write(11, 32'hFFFF_FFFF);
        dbg_write(10, 32'h99);
        dbg_write(12, 32'h99);
        dbg_write(20, 32'h0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        clear_prog();
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_state", {29'b0, dbg_state}, {29'b0, S_IDLE});
        chk("rst_pc", pc, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_req", {31'b0, instr_req}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_illegal", {31'b0, illegal}, 32'd0);
        rst_n = 1'b1;

        // R0 ignores debug writes
        dbg_write(0, 32'h55);
        expect_reg(0, 32'h0);
        drain_regs("r0_dbg");

        // main ALU program, zero-wait memory
        preload_a();
        load_prog_a();
        run_prog(-1);
        chk("a_cycles", run_cycles, 32'd124);
        chk("a_instr0_len", hs_cyc[1] - hs_cyc[0], 32'd4);
        chk("a_instr1_len", hs_cyc[2] - hs_cyc[1], 32'd4);
        chk("a_done_pulses", run_dones, 32'd1);
        chk("a_halt_pc", pc, 32'd124);
        chk("a_busy_after", {31'b0, busy}, 32'd0);
        chk("a_illegal", {31'b0, illegal}, 32'd0);
`ifdef PERF_CNT_EN
        chk("a_perf_cycles", cycle_cnt, 32'd124);
        chk("a_perf_instr", instr_cnt, 32'd31);
        chk("a_perf_stall", stall_cnt, 32'd0);
`endif
        expect_prog_a();
        drain_regs("a");

        // three wait cycles on the fetch at address 4
        load_prog_a();
        stall_at[1] = 3;
        run_prog(-1);
        chk("stall_cycles_seen", stall_seen, 32'd3);
        chk("stall_pc_stable", stall_pc, 32'd4);
        chk("stall_instr1_len", hs_cyc[1] - hs_cyc[0], 32'd7);
        chk("stall_total", run_cycles, 32'd127);
        chk("stall_halt_pc", pc, 32'd124);
`ifdef PERF_CNT_EN
        chk("stall_perf_stall", stall_cnt, 32'd3);
`endif
        expect_prog_a();
        drain_regs("stall");

        // illegal opcode at 8, unsupported funct at 16
        dbg_write(1, 32'd7);
        dbg_write(8, 32'h1234);
        dbg_write(19, 32'h77);
        clear_prog();
        imem[0] = r_ins(1, 2, 3, 0, 'h20);
        imem[1] = r_ins(1, 2, 0, 0, 'h20);
        imem[2] = {6'h23, 5'd1, 5'd2, 5'd8, 5'd0, 6'h20};
        imem[3] = r_ins(1, 2, 21, 0, 'h22);
        imem[4] = r_ins(1, 2, 19, 0, 'h21);
        imem[5] = r_ins(1, 2, 22, 0, 'h24);
        run_prog(-1);
        chk("ill_flag", {31'b0, illegal}, 32'd1);
        chk("ill_done_pulses", run_dones, 32'd1);
        chk("ill_halt_pc", pc, 32'd124);
        expect_reg(0, 32'h0);
        expect_reg(3, 32'd10);
        expect_reg(8, 32'h1234);
        expect_reg(21, 32'd4);
        expect_reg(19, 32'h77);
        expect_reg(22, 32'd3);
        drain_regs("ill");

        // restart from HALT clears illegal; start and dbg_we mid-run are ignored
        preload_a();
        load_prog_a();
        run_prog(50);
        chk("restart_ill_clear", {31'b0, ill_at_start}, 32'd0);
        chk("restart_ill_end", {31'b0, illegal}, 32'd0);
        chk("restart_cycles", run_cycles, 32'd124);
        chk("restart_done_pulses", run_dones, 32'd1);
        chk("restart_halt_pc", pc, 32'd124);
        expect_prog_a();
        expect_reg(20, 32'h0);
        drain_regs("restart");

        // async reset during EXEC of add $6
        dbg_write(6, 32'h66);
        clear_prog();
        imem[0] = r_ins(1, 2, 6, 0, 'h20);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_in_exec", {29'b0, dbg_state}, {29'b0, S_EXEC});
        rst_n = 1'b0;
        #1;
        chk("rst_mid_state", {29'b0, dbg_state}, {29'b0, S_IDLE});
        chk("rst_mid_busy", {31'b0, busy}, 32'd0);
        chk("rst_mid_req", {31'b0, instr_req}, 32'd0);
        chk("rst_mid_pc", pc, 32'h0);
        expect_reg(1, 32'h0);
        expect_reg(2, 32'h0);
        expect_reg(6, 32'h0);
        expect_reg(11, 32'h0);
        drain_regs("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_mid_after_state", {29'b0, dbg_state}, {29'b0, S_IDLE});
        expect_reg(6, 32'h0);
        drain_regs("rst_mid_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
